// File: rtl/mem_sdram_splat_pkg.sv
// Shared types and constants for the SDRAM splat engine.
package mem_sdram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int unsigned CC_W    = 32;
   localparam logic [3:0]  BYTE_EN = 4'hF;

endpackage

// File: rtl/mem_sdram_splat_if.sv
// Avalon-MM write-only master bundle used by the splat engine.
interface mem_sdram_splat_if #(
   parameter int unsigned ADDR_W = 25
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic [3:0]        avm_byteenable;
   logic              avm_waitrequest;

   modport master (
      output avm_address,
      output avm_write,
      output avm_writedata,
      output avm_byteenable,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_address,
      input  avm_write,
      input  avm_writedata,
      input  avm_byteenable,
      output avm_waitrequest
   );
endinterface

// File: rtl/mem_sdram_splat.sv
// Fills a fixed SDRAM region with an index^SEED pattern on a rising splat edge,
// then pulses done and reports the run's cycle count on cc.
module mem_sdram_splat
   import mem_sdram_pkg::*;
#(
   parameter int unsigned ADDR_W = 25,
   parameter int unsigned BASE   = 0,
   parameter int unsigned WORDS  = 1024,
   parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                splat,
   mem_sdram_splat_if.master   avm,
   output logic                busy,
   output logic                done,
   output logic [CC_W-1:0]     cc
);

   localparam int unsigned     IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_e            state_q, state_d;
   logic              splat_q;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CC_W-1:0]   run_cnt_q, run_cnt_d;
   logic [CC_W-1:0]   cc_q, cc_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Address arithmetic stays in ADDR_W bits so regions near the top wrap to 0.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] i);
      return ADDR_W'(BASE) + ADDR_W'({i, 2'b00});
   endfunction

   function automatic logic [31:0] word_data(input logic [IDX_W-1:0] i);
      return 32'(i) ^ SEED;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         splat_q   <= 1'b0;
         idx_q     <= '0;
         run_cnt_q <= '0;
         cc_q      <= '0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         splat_q   <= splat;
         idx_q     <= idx_d;
         run_cnt_q <= run_cnt_d;
         cc_q      <= cc_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      run_cnt_d = run_cnt_q;
      cc_d      = cc_q;
      write_d   = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // Edges arriving outside IDLE are dropped, never queued.
            if (splat && !splat_q) begin
               state_d   = WRITE;
               idx_d     = '0;
               run_cnt_d = '0;
               write_d   = 1'b1;
               addr_d    = word_addr('0);
               data_d    = word_data('0);
            end
         end
         WRITE: begin
            // Counts stall cycles too; saturates instead of wrapping.
            run_cnt_d = run_cnt_q + CC_W'(run_cnt_q != '1);
            write_d   = 1'b1;
            if (write_q && !avm.avm_waitrequest) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  write_d = 1'b0;
                  cc_d    = run_cnt_d;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  addr_d = word_addr(idx_d);
                  data_d = word_data(idx_d);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == WRITE);
   end

   assign avm.avm_address    = addr_q;
   assign avm.avm_write      = write_q;
   assign avm.avm_writedata  = data_q;
   assign avm.avm_byteenable = BYTE_EN;
   assign busy               = busy_q;
   assign done               = done_q;
   assign cc                 = cc_q;

endmodule

// File: tb/tb_mem_sdram_splat.sv
// Self-checking bench for mem_sdram_splat: cycle-exact expectations derived from
// the run rules (write i at BASE+4i with data i^SEED, cc = words + stall cycles).
module tb_mem_sdram_splat;

   localparam int unsigned ADDR_W = 25;
   localparam int unsigned WORDS  = 4;
   localparam int unsigned BASE0  = 32'h100;
   localparam int unsigned BASE1  = (32'd1 << ADDR_W) - 32'd8;
   localparam logic [31:0] SEED   = 32'hA5A5_0000;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        splat0 = 1'b0;
   logic        splat1 = 1'b0;
   logic        wait0  = 1'b0;
   logic        wait1  = 1'b0;
   logic        busy0, done0, busy1, done1;
   logic [31:0] cc0, cc1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ADDR_W-1:0] acc_addr[$];
   logic [31:0]       acc_data[$];
   int                done_cnt = 0;
   logic [31:0]       done_cc  = '0;

   mem_sdram_splat_if #(.ADDR_W(ADDR_W)) avm0 ();
   mem_sdram_splat_if #(.ADDR_W(ADDR_W)) avm1 ();

   assign avm0.avm_waitrequest = wait0;
   assign avm1.avm_waitrequest = wait1;

   always #5 clk = ~clk;

   mem_sdram_splat #(.ADDR_W(ADDR_W), .BASE(BASE0), .WORDS(WORDS), .SEED(SEED)) dut0 (
      .clk   (clk),
      .rst   (rst),
      .splat (splat0),
      .avm   (avm0.master),
      .busy  (busy0),
      .done  (done0),
      .cc    (cc0)
   );

   mem_sdram_splat #(.ADDR_W(ADDR_W), .BASE(BASE1), .WORDS(WORDS), .SEED(SEED)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .splat (splat1),
      .avm   (avm1.master),
      .busy  (busy1),
      .done  (done1),
      .cc    (cc1)
   );

   // Record every accepted write and every done pulse of dut0.
   always @(posedge clk) begin
      if (!rst) begin
         if (avm0.avm_write && !avm0.avm_waitrequest) begin
            acc_addr.push_back(avm0.avm_address);
            acc_data.push_back(avm0.avm_writedata);
         end
         if (done0) begin
            done_cnt <= done_cnt + 1;
            done_cc  <= cc0;
         end
      end
   end

   function automatic logic [ADDR_W-1:0] exp_addr(input longint unsigned base, input int unsigned i);
      longint unsigned a;
      a = (base + 64'(i) * 64'd4) % (64'd1 << ADDR_W);
      return ADDR_W'(a);
   endfunction

   function automatic logic [31:0] exp_data(input int unsigned i);
      return 32'(i) ^ SEED;
   endfunction

   task automatic test_reset();
      rst    = 1'b1;
      splat0 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if ({avm0.avm_write, busy0, done0, cc0} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_values cyc=%0d: got write=%b busy=%b done=%b cc=%h, expected all 0",
                     k, avm0.avm_write, busy0, done0, cc0);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (avm0.avm_write !== 1'b1 || avm0.avm_address !== exp_addr(BASE0, 0)) begin
         n_fail++;
         $display("FAIL reset_release_start: got write=%b addr=%h, expected write=1 addr=%h",
                  avm0.avm_write, avm0.avm_address, exp_addr(BASE0, 0));
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (done0 !== 1'b1 || cc0 !== 32'd4) begin
         n_fail++;
         $display("FAIL reset_release_done: got done=%b cc=%h, expected done=1 cc=4", done0, cc0);
      end
      splat0 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic();
      acc_addr.delete();
      acc_data.delete();
      splat0 = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         logic ew, ed;
         @(negedge clk);
         splat0 = 1'b0;
         ew = (k >= 1 && k <= 4);
         ed = (k == 5);
         n_checks++;
         if (avm0.avm_write !== ew || busy0 !== ew || done0 !== ed) begin
            n_fail++;
            $display("FAIL basic_ctrl k=%0d: got write=%b busy=%b done=%b, expected %b %b %b",
                     k, avm0.avm_write, busy0, done0, ew, ew, ed);
         end
         if (ew) begin
            n_checks++;
            if (avm0.avm_address !== exp_addr(BASE0, k - 1) || avm0.avm_writedata !== exp_data(k - 1)
                || avm0.avm_byteenable !== 4'hF) begin
               n_fail++;
               $display("FAIL basic_word k=%0d: got addr=%h data=%h be=%h, expected %h %h f",
                        k, avm0.avm_address, avm0.avm_writedata, avm0.avm_byteenable,
                        exp_addr(BASE0, k - 1), exp_data(k - 1));
            end
         end
         if (ed) begin
            n_checks++;
            if (cc0 !== 32'd4) begin
               n_fail++;
               $display("FAIL basic_cc: got %h expected 4", cc0);
            end
         end
      end
   endtask

   task automatic test_stall();
      acc_addr.delete();
      acc_data.delete();
      splat0 = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         splat0 = 1'b0;
         n_checks++;
         if (done0 !== (k == 8)) begin
            n_fail++;
            $display("FAIL stall_done k=%0d: got %b expected %b", k, done0, (k == 8));
         end
         if (k >= 2 && k <= 5) begin
            n_checks++;
            if (avm0.avm_write !== 1'b1 || avm0.avm_address !== exp_addr(BASE0, 1)
                || avm0.avm_writedata !== exp_data(1)) begin
               n_fail++;
               $display("FAIL stall_hold k=%0d: got write=%b addr=%h data=%h, expected 1 %h %h",
                        k, avm0.avm_write, avm0.avm_address, avm0.avm_writedata,
                        exp_addr(BASE0, 1), exp_data(1));
            end
         end
         if (k == 8) begin
            n_checks++;
            if (cc0 !== 32'd7) begin
               n_fail++;
               $display("FAIL stall_cc: got %h expected 7", cc0);
            end
         end
         wait0 = (k >= 2 && k <= 4);
      end
      wait0 = 1'b0;
      n_checks++;
      if (acc_addr.size() != WORDS) begin
         n_fail++;
         $display("FAIL stall_count: got %0d writes expected %0d", acc_addr.size(), WORDS);
      end else begin
         for (int i = 0; i < int'(WORDS); i++) begin
            n_checks++;
            if (acc_addr[i] !== exp_addr(BASE0, i) || acc_data[i] !== exp_data(i)) begin
               n_fail++;
               $display("FAIL stall_seq i=%0d: got %h/%h expected %h/%h",
                        i, acc_addr[i], acc_data[i], exp_addr(BASE0, i), exp_data(i));
            end
         end
      end
   endtask

   task automatic test_random_stall();
      for (int r = 0; r < 3; r++) begin
         bit stall [0:63];
         int accepted;
         int exp_cc;
         for (int c = 0; c < 64; c++) stall[c] = (c >= 1 && c < 40) ? ($urandom_range(0, 2) == 0) : 1'b0;
         accepted = 0;
         exp_cc   = 0;
         for (int c = 1; accepted < int'(WORDS); c++) begin
            if (!stall[c]) accepted++;
            exp_cc = c;
         end
         acc_addr.delete();
         acc_data.delete();
         splat0 = 1'b1;
         for (int k = 1; k <= exp_cc + 3; k++) begin
            @(negedge clk);
            splat0 = 1'b0;
            n_checks++;
            if (done0 !== (k == exp_cc + 1) || busy0 !== (k <= exp_cc)) begin
               n_fail++;
               $display("FAIL rand_ctrl r=%0d k=%0d: got done=%b busy=%b, expected %b %b",
                        r, k, done0, busy0, (k == exp_cc + 1), (k <= exp_cc));
            end
            if (k == exp_cc + 1) begin
               n_checks++;
               if (cc0 !== 32'(exp_cc)) begin
                  n_fail++;
                  $display("FAIL rand_cc r=%0d: got %0d expected %0d", r, cc0, exp_cc);
               end
            end
            wait0 = (k < 64) ? stall[k] : 1'b0;
         end
         wait0 = 1'b0;
         n_checks++;
         if (acc_addr.size() != WORDS) begin
            n_fail++;
            $display("FAIL rand_count r=%0d: got %0d writes expected %0d", r, acc_addr.size(), WORDS);
         end else begin
            for (int i = 0; i < int'(WORDS); i++) begin
               n_checks++;
               if (acc_addr[i] !== exp_addr(BASE0, i) || acc_data[i] !== exp_data(i)) begin
                  n_fail++;
                  $display("FAIL rand_seq r=%0d i=%0d: got %h/%h expected %h/%h",
                           r, i, acc_addr[i], acc_data[i], exp_addr(BASE0, i), exp_data(i));
               end
            end
         end
      end
   endtask

   task automatic test_ignored_edges();
      int d;
      acc_addr.delete();
      acc_data.delete();
      d      = done_cnt;
      splat0 = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1 || k == 3) splat0 = 1'b0;
         if (k == 2 || k == 4) splat0 = 1'b1;
      end
      n_checks++;
      if (done_cnt - d != 1 || acc_addr.size() != WORDS || avm0.avm_write !== 1'b0) begin
         n_fail++;
         $display("FAIL ignored_edges: got dones=%0d writes=%0d write=%b, expected 1 %0d 0",
                  done_cnt - d, acc_addr.size(), avm0.avm_write, WORDS);
      end
      // Second run with two stalls on word 0 must overwrite cc (4 -> 6).
      splat0 = 1'b0;
      @(negedge clk);
      splat0 = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         splat0 = 1'b0;
         if (k == 7) begin
            n_checks++;
            if (done0 !== 1'b1 || cc0 !== 32'd6) begin
               n_fail++;
               $display("FAIL second_run_done: got done=%b cc=%h expected 1 6", done0, cc0);
            end
         end
         wait0 = (k <= 2);
      end
      wait0 = 1'b0;
      n_checks++;
      if (cc0 !== 32'd6) begin
         n_fail++;
         $display("FAIL cc_hold: got %h expected 6", cc0);
      end
   endtask

   task automatic test_restart_boundary();
      splat0 = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         logic ew, ed;
         @(negedge clk);
         ew = (k >= 1 && k <= 4) || (k >= 10 && k <= 13) || (k >= 16 && k <= 19);
         ed = (k == 5) || (k == 14) || (k == 20);
         n_checks++;
         if (avm0.avm_write !== ew || done0 !== ed) begin
            n_fail++;
            $display("FAIL restart k=%0d: got write=%b done=%b expected %b %b",
                     k, avm0.avm_write, done0, ew, ed);
         end
         case (k)
            1, 8, 10, 21: splat0 = 1'b0;
            5, 9, 15:     splat0 = 1'b1;
            default: ;
         endcase
      end
   endtask

   task automatic test_reset_mid();
      int d;
      d      = done_cnt;
      splat0 = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         splat0 = 1'b0;
         if (k == 3) begin
            n_checks++;
            if (avm0.avm_address !== exp_addr(BASE0, 2)) begin
               n_fail++;
               $display("FAIL mid_word2: got %h expected %h", avm0.avm_address, exp_addr(BASE0, 2));
            end
            rst = 1'b1;
         end else if (k == 4) begin
            n_checks++;
            if ({avm0.avm_write, busy0, done0, cc0} !== 35'd0) begin
               n_fail++;
               $display("FAIL mid_reset: got write=%b busy=%b done=%b cc=%h expected all 0",
                        avm0.avm_write, busy0, done0, cc0);
            end
            rst = 1'b0;
         end else if (k > 4) begin
            n_checks++;
            if (done0 !== 1'b0 || avm0.avm_write !== 1'b0) begin
               n_fail++;
               $display("FAIL mid_quiet k=%0d: got done=%b write=%b expected 0 0", k, done0, avm0.avm_write);
            end
         end
      end
      n_checks++;
      if (done_cnt != d) begin
         n_fail++;
         $display("FAIL mid_no_done: got %0d dones expected 0", done_cnt - d);
      end
   endtask

   task automatic test_saturation();
      splat0 = 1'b1;
      wait0  = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1) splat0 = 1'b0;
         if (k == 2) force dut0.run_cnt_q = 32'hFFFF_FFFF;
         if (k == 6) wait0 = 1'b0;
         if (k == 10) begin
            n_checks++;
            if (done0 !== 1'b1 || cc0 !== 32'hFFFF_FFFF) begin
               n_fail++;
               $display("FAIL saturate: got done=%b cc=%h expected 1 ffffffff", done0, cc0);
            end
         end
         if (k == 11) release dut0.run_cnt_q;
      end
      n_checks++;
      if (cc0 !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL saturate_hold: got %h expected ffffffff", cc0);
      end
   endtask

   task automatic test_wrap();
      splat1 = 1'b1;
      wait1  = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         logic ew;
         @(negedge clk);
         splat1 = 1'b0;
         ew = (k <= 4);
         n_checks++;
         if (avm1.avm_write !== ew || busy1 !== ew || done1 !== (k == 5)) begin
            n_fail++;
            $display("FAIL wrap_ctrl k=%0d: got write=%b busy=%b done=%b expected %b %b %b",
                     k, avm1.avm_write, busy1, done1, ew, ew, (k == 5));
         end
         if (ew) begin
            n_checks++;
            if (avm1.avm_address !== exp_addr(BASE1, k - 1) || avm1.avm_writedata !== exp_data(k - 1)
                || avm1.avm_byteenable !== 4'hF) begin
               n_fail++;
               $display("FAIL wrap_word k=%0d: got addr=%h data=%h be=%h expected %h %h f",
                        k, avm1.avm_address, avm1.avm_writedata, avm1.avm_byteenable,
                        exp_addr(BASE1, k - 1), exp_data(k - 1));
            end
         end
         if (k == 5) begin
            n_checks++;
            if (cc1 !== 32'd4) begin
               n_fail++;
               $display("FAIL wrap_cc: got %h expected 4", cc1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_random_stall();
      test_ignored_edges();
      test_restart_boundary();
      test_reset_mid();
      test_saturation();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
